// File: rtl/imem_pkg.sv
// Shared types and defaults for the imem loader and the imem it fills.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the trailer word.
package imem_pkg;

  localparam int IMEM_N = 32;
  localparam int IMEM_R = 7;
  localparam int BPW    = IMEM_N / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } loader_state_t;

  function automatic int cnt_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into one word.
// word_valid pulses in the cycle after the top byte lane is filled.
module imem_byte_packer
  import imem_pkg::*;
#(
  parameter int N = IMEM_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         shift,
  input  logic [7:0]   in_data,
  output logic         last,
  output logic         word_valid,
  output logic [N-1:0] word
);

  localparam int NB = N / 8;
  localparam int CW = cnt_w(NB);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  word_q, word_d;
  logic          wv_q, wv_d;

  assign last       = (cnt_q == CW'(NB - 1));
  assign word_valid = wv_q;
  assign word       = word_q;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    wv_d   = 1'b0;
    if (clr) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift) begin
      word_d[cnt_q*8 +: 8] = in_data;
      wv_d  = last;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
      wv_q   <= wv_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into imem words at consecutive addresses, then flags done.
// IMEM_LOADER_CHECKSUM_EN: expects an XOR trailer word after the last write.
module imem_loader
  import imem_pkg::*;
#(
  parameter int n = IMEM_N,
  parameter int r = IMEM_R
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [r:0]   len,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         mem_we,
  output logic [r-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [r:0] CAP = {1'b1, {r{1'b0}}};

  loader_state_t state_q, state_d;
  logic [r:0]    len_q, len_d;
  logic [r:0]    wcnt_q, wcnt_d;
  logic [r:0]    wnext;
  logic [r-1:0]  addr_q, addr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          idle_like, start_ok, hs;
  logic          last, word_valid;
  logic [n-1:0]  word;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start_ok  = start && idle_like;
  assign hs        = in_valid && in_ready;
  assign wnext     = wcnt_q + 1'b1;

  imem_byte_packer #(.N(n)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_ok),
    .shift      (hs),
    .in_data    (in_data),
    .last       (last),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [n-1:0] csum_q, csum_d;
  logic [n-1:0] trailer;

  // top lane arrives on the accepting edge, lower lanes are already held
  assign trailer  = {in_data, word[n-9:0]};
  assign in_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign busy     = (state_q == S_RECV) || (state_q == S_WRITE) ||
                    (state_q == S_CHECK);
`else
  assign in_ready = (state_q == S_RECV);
  assign busy     = (state_q == S_RECV) || (state_q == S_WRITE);
`endif

  assign mem_we    = (state_q == S_WRITE) && word_valid;
  assign mem_addr  = addr_q;
  assign mem_wdata = word;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (len == '0 || len > CAP) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_RECV;
            len_d   = len;
            wcnt_d  = '0;
            addr_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end
        end
      end
      S_RECV: begin
        if (hs && last) begin
          state_d = S_WRITE;
          addr_d  = wcnt_q[r-1:0];
        end
      end
      S_WRITE: begin
        wcnt_d = wnext;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ word;
        if (wnext == len_q) begin
          state_d = S_CHECK;
        end else begin
          state_d = S_RECV;
        end
`else
        if (wnext == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RECV;
        end
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (hs && last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = (trailer != csum_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued as bytes are
// driven, checked by a monitor whenever mem_we is seen.
module tb_imem_loader;

  localparam int N = 32;
  localparam int R = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [R:0]   len = '0;
  logic         in_valid = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_ready;
  logic         mem_we;
  logic [R-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         busy;
  logic         done;
  logic         err;

  imem_loader #(.n(N), .r(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [R-1:0] a;
    logic [N-1:0] d;
  } wr_t;

  wr_t          exp_q[$];
  wr_t          mon_e;
  int           n_checks = 0;
  int           n_fails = 0;
  int           n_writes = 0;
  logic [N-1:0] csum = '0;
  logic [R-1:0] next_addr = '0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== {mon_e.a, mon_e.d}) begin
          n_fails++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                   mem_addr, mem_wdata, mon_e.a, mon_e.d);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 64) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (t >= 64) begin
      n_checks++;
      n_fails++;
      $display("FAIL byte_timeout byte=%h in_ready=%b exp 1", b, in_ready);
    end
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap);
    exp_q.push_back('{a: next_addr, d: w});
    csum = csum ^ w;
    next_addr = next_addr + 1'b1;
    for (int i = 0; i < N / 8; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic send_raw(input logic [N-1:0] w);
    for (int i = 0; i < N / 8; i++) send_byte(w[8*i +: 8], 0);
  endtask

  task automatic do_start(input logic [R:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    csum = '0;
    next_addr = '0;
  endtask

  task automatic finish_load;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_raw(csum);
`else
    @(negedge clk);
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_flags got %b exp 00000",
               {in_ready, mem_we, busy, done, err});
    end
    n_checks++;
    if (mem_addr !== '0) begin
      n_fails++;
      $display("FAIL reset_addr got %h exp 0", mem_addr);
    end
    n_checks++;
    if (mem_wdata !== '0) begin
      n_fails++;
      $display("FAIL reset_wdata got %h exp 0", mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_start(9'(2));
    n_checks++;
    if ({in_ready, busy} !== 2'b11) begin
      n_fails++;
      $display("FAIL start_ready got %b exp 11", {in_ready, busy});
    end
    send_word(32'h1234_5678, 0);
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_fails++;
      $display("FAIL write_latency mem_we got %b exp 1", mem_we);
    end
    send_word(32'hDEAD_BEEF, 0);
    finish_load();
    n_checks++;
    if ({done, err, busy, mem_we} !== 4'b1000) begin
      n_fails++;
      $display("FAIL basic_done got d/e/b/we=%b exp 1000",
               {done, err, busy, mem_we});
    end
    n_checks++;
    if (mem_addr !== 7'h01 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL basic_end addr=%h pending=%0d exp addr=01 pending=0",
               mem_addr, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    do_start(9'(1));
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fails++;
      $display("FAIL midreset_outs got %b %h %h exp 00000 00 00000000",
               {in_ready, mem_we, busy, done, err}, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_start(9'(1));
    send_word(32'hA5C3_0F1E, 0);
    finish_load();
    n_checks++;
    if ({done, err} !== 2'b10 || mem_addr !== '0 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL midreset_reload d/e=%b addr=%h pending=%0d exp 10 00 0",
               {done, err}, mem_addr, exp_q.size());
    end
  endtask

  task automatic test_bad_len(input logic [R:0] l);
    int w0;
    w0 = n_writes;
    do_start(l);
    n_checks++;
    if ({done, err, busy, in_ready} !== 4'b1100) begin
      n_fails++;
      $display("FAIL bad_len_%0d d/e/b/rdy got %b exp 1100",
               l, {done, err, busy, in_ready});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (n_writes != w0) begin
      n_fails++;
      $display("FAIL bad_len_%0d_writes got %0d exp 0", l, n_writes - w0);
    end
  endtask

  task automatic test_full;
    int w0;
    w0 = n_writes;
    do_start(9'(128));
    for (int i = 0; i < 128; i++) begin
      if (i == 10) begin
        start = 1'b1;
        len   = 9'(5);
      end
      send_word({8'(i), 8'(~i), 8'(i * 3), 8'hA5}, 0);
      start = 1'b0;
    end
    finish_load();
    n_checks++;
    if ({done, err, busy} !== 3'b100 || mem_addr !== 7'h7F) begin
      n_fails++;
      $display("FAIL full_end d/e/b=%b addr=%h exp 100 7f",
               {done, err, busy}, mem_addr);
    end
    n_checks++;
    if (n_writes - w0 != 128 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL full_count writes=%0d pending=%0d exp 128 0",
               n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_toggle;
    int w0;
    w0 = n_writes;
    do_start(9'(3));
    send_word(32'h0BAD_F00D, 1);
    send_word(32'hCAFE_1234, 1);
    send_word(32'h8000_0001, 1);
    finish_load();
    n_checks++;
    if ({done, err} !== 2'b10 || n_writes - w0 != 3 ||
        mem_addr !== 7'h02 || exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL toggle d/e=%b writes=%0d addr=%h exp 10 3 02",
               {done, err}, n_writes - w0, mem_addr);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum(input logic [N-1:0] trl, input logic exp_err);
    int w0;
    w0 = n_writes;
    do_start(9'(2));
    send_word(32'h1234_5678, 0);
    send_word(32'hDEAD_BEEF, 0);
    n_checks++;
    if (done !== 1'b0) begin
      n_fails++;
      $display("FAIL csum_early_done got %b exp 0", done);
    end
    send_raw(trl);
    n_checks++;
    if ({done, err, busy} !== {1'b1, exp_err, 1'b0}) begin
      n_fails++;
      $display("FAIL csum_%h d/e/b got %b exp %b",
               trl, {done, err, busy}, {1'b1, exp_err, 1'b0});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (n_writes - w0 != 2) begin
      n_fails++;
      $display("FAIL csum_writes got %0d exp 2", n_writes - w0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_bad_len(9'(0));
    test_bad_len(9'(129));
    test_full();
    test_toggle();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum(32'hCC99_E897, 1'b0);
    test_checksum(32'h0000_0000, 1'b1);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills instruction memory before the core starts fetching. It accepts a byte stream over a valid/ready handshake and packs it little-endian into n-bit instruction words. It writes those words to consecutive imem addresses through a single-cycle write port, then flags completion. It sits between the host/UART byte source and the write side of imem; the fetch path uses the read side.

## Interface
- n, 32, instruction word width in bits; must be a multiple of 8 (BPW = n/8 bytes per word)
- r, 7, imem address width; capacity 2^r words
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE or DONE
- len  in  r+1  word count, sampled when start is accepted; valid range 1..2^r
- in_valid  in  1  byte source has data
- in_data  in  8  byte payload
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  imem write strobe, one cycle per word
- mem_addr  out  r  imem write address
- mem_wdata  out  n  imem write data
- busy  out  1  load in progress
- done  out  1  load finished; held until the next accepted start or reset
- err  out  1  load aborted or failed; held until the next accepted start or reset

## Operation
- States: IDLE, RECV, WRITE, DONE. CHECK is added only under the config macro.
- IDLE/DONE with start=1:
  - If len==0 or len>2^r, go to DONE with err=1 and done=1. No writes occur.
  - Otherwise latch len, clear the word counter, byte counter, address, done, err and checksum, then go to RECV.
- RECV:
  - in_ready=1. Each handshake (in_valid && in_ready) shifts in_data into byte lane byte_cnt. Byte 0 is bits [7:0].
  - When byte BPW-1 is accepted, go to WRITE.
- WRITE:
  - mem_we=1 for exactly one cycle; mem_addr = word counter, mem_wdata = assembled word; in_ready=0.
  - Then the word counter increments. If word counter+1 == len, go to DONE (or CHECK when enabled); otherwise go to RECV.
- DONE: done=1, busy=0. The last written address stays on mem_addr.
- busy=1 in RECV, WRITE and CHECK.
- The address counter is r bits. A len=2^r load ends at address 2^r-1 and never wraps to 0.
- in_valid while in IDLE, DONE or WRITE is not consumed; the source holds its byte.
- start while busy is ignored.
- Reset at any point, including mid-word: return to IDLE and discard the partial word. No write strobe is issued for it.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0.
- Start is accepted at edge k; in_ready=1 from cycle k+1.
- The 4th byte is accepted at edge j; mem_we=1 during cycle j+1.
- Peak rate: BPW+1 cycles per word with in_valid held high.
- done rises in the cycle after the last WRITE (no checksum) or after the CHECK cycle.
- All outputs are registered or decoded from state only; there are no combinational paths from in_valid or start to outputs.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - A running XOR of all written words is kept.
  - After the last WRITE, the loader enters CHECK and receives one extra BPW-byte word, which is not written to imem.
  - If that word equals the XOR, go to DONE with err=0; otherwise go to DONE with err=1. done=1 in both cases.
- Macro undefined: no CHECK state and no extra word. err is set only by an illegal len.

## Structure
- Package imem_pkg holds the state enum type (loader_state_t), the BPW constant and the default n/r values; imem uses the same package.
- Sub-module imem_byte_packer: byte shift register plus byte counter. It outputs word_valid and word, and is cleared on start or reset. The top level holds the FSM, address/word counters and checksum.

## Test plan
- Reset, then start with len=2, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 1; done=1, err=0.
- Reset asserted after 2 bytes of the first word -> no mem_we; all outputs return to reset values; the next load starts at addr 0.
- len=0 and len=129 (r=7) -> done=1 and err=1 the cycle after start, with zero writes.
- len=128 with 512 bytes streamed -> last write at addr 0x7F, no wrap; done=1; start during busy is ignored.
- in_valid toggled every other cycle -> identical written data, with one mem_we per 4 accepted bytes.
- With IMEM_LOADER_CHECKSUM_EN, len=2 words 0x12345678 and 0xDEADBEEF:
  - Trailer 0xCC99E897 -> err=0.
  - Trailer 0x00000000 -> err=1.
  - The trailer is never written in either case.
